vectorial_register_file_lanes: RTL and testbench

VECTORIAL_REGISTER_FILE_LANES -- requirements
Module: vectorial_register_file_lanes

---
 rtl/vectorial_register_file_lanes_if.sv | 37 +++
 rtl/vectorial_register_file_lanes.sv | 75 +++++++
 tb/tb_vectorial_register_file_lanes.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vectorial_register_file_lanes_if.sv
// vectorial_register_file_lanes_if: bus bundle for the lane-masked vector register file.
// Ports (master drives requests, slave returns data/status):
//   address1/address2 - read addresses, addressw - write address
//   writeData/writeMask/writeEn - lane-masked write request
//   readEn - read request for both read ports, clearStart - start zeroing all registers
//   read1/read2/readValid - registered read data and its valid strobe
//   busy/clearDone/writeReject - clear sequence status and dropped-write pulse
interface vectorial_register_file_lanes_if #(
    parameter int DEPTH     = 16,
    parameter int LANES     = 4,
    parameter int LANE_BITS = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = LANES * LANE_BITS;
    logic [AW-1:0]    address1;
    logic [AW-1:0]    address2;
    logic [AW-1:0]    addressw;
    logic [VW-1:0]    writeData;
    logic [LANES-1:0] writeMask;
    logic             writeEn;
    logic             readEn;
    logic             clearStart;
    logic [VW-1:0]    read1;
    logic [VW-1:0]    read2;
    logic             readValid;
    logic             busy;
    logic             clearDone;
    logic             writeReject;
    modport master (
        output address1, address2, addressw, writeData, writeMask, writeEn, readEn, clearStart,
        input  read1, read2, readValid, busy, clearDone, writeReject
    );
    modport slave (
        input  address1, address2, addressw, writeData, writeMask, writeEn, readEn, clearStart,
        output read1, read2, readValid, busy, clearDone, writeReject
    );
endinterface

// File: rtl/vectorial_register_file_lanes.sv
// vectorial_register_file_lanes: DEPTH x (LANES*LANE_BITS) register file with lane-masked writes, two registered read ports, write-to-read bypass and a sequential clear.
// Ports: clk - rising-edge clock; rst_n - asynchronous active-low reset;
//   bus - slave side of vectorial_register_file_lanes_if (requests in, read data and status out).
module vectorial_register_file_lanes #(
    parameter int DEPTH     = 16,
    parameter int LANES     = 4,
    parameter int LANE_BITS = 32,
    parameter int ZERO_REG  = 1
) (
    input logic clk,
    input logic rst_n,
    vectorial_register_file_lanes_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = LANES * LANE_BITS;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nx;
    logic [AW-1:0] count;
    logic [VW-1:0] regs [DEPTH];
    logic [VW-1:0] wr_val, rd1_val, rd2_val, read1, read2;
    logic busy, clear_done, wr_acc, rd_acc, read_valid, write_reject;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // clearStart is only looked at in IDLE, so a request during CLEAR cannot restart the count
    always_comb
        state_nx = (state == IDLE) ? (bus.clearStart ? CLEAR : IDLE) : (count == LAST ? IDLE : CLEAR);
    always_comb begin
        busy       = (state == CLEAR);
        clear_done = (state == CLEAR) && (count == LAST);
    end
    // register 0 is never written when hardwired, which also disables its bypass
    assign wr_acc = bus.writeEn && !busy && !(ZERO_REG != 0 && bus.addressw == '0);
    assign rd_acc = bus.readEn && !busy;
    always_comb begin
        wr_val  = regs[bus.addressw];
        rd1_val = regs[bus.address1];
        rd2_val = regs[bus.address2];
        for (int k = 0; k < LANES; k++) begin
            if (bus.writeMask[k]) wr_val[k*LANE_BITS +: LANE_BITS] = bus.writeData[k*LANE_BITS +: LANE_BITS];
            if (wr_acc && bus.writeMask[k] && bus.addressw == bus.address1)
                rd1_val[k*LANE_BITS +: LANE_BITS] = bus.writeData[k*LANE_BITS +: LANE_BITS];
            if (wr_acc && bus.writeMask[k] && bus.addressw == bus.address2)
                rd2_val[k*LANE_BITS +: LANE_BITS] = bus.writeData[k*LANE_BITS +: LANE_BITS];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            count        <= '0;
            read1        <= '0;
            read2        <= '0;
            read_valid   <= 1'b0;
            write_reject <= 1'b0;
        end else begin
            // wr_acc and busy are exclusive, so these two writes never collide
            if (wr_acc) regs[bus.addressw] <= wr_val;
            if (busy) regs[count] <= '0;
            // DEPTH is a power of two, so the increment wraps back to 0 after the last clear cycle
            count        <= busy ? count + AW'(1) : '0;
            read_valid   <= rd_acc;
            write_reject <= bus.writeEn && busy;
            if (rd_acc) begin
                read1 <= rd1_val;
                read2 <= rd2_val;
            end
        end
    assign bus.read1       = read1;
    assign bus.read2       = read2;
    assign bus.readValid   = read_valid;
    assign bus.busy        = busy;
    assign bus.clearDone   = clear_done;
    assign bus.writeReject = write_reject;
endmodule

// File: tb/tb_vectorial_register_file_lanes.sv
// tb_vectorial_register_file_lanes: scoreboard bench for vectorial_register_file_lanes (masked write, bypass, zero register, clear, reset mid-clear).
module tb_vectorial_register_file_lanes;
    localparam int W  = 32;
    localparam int VW = 128;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    vectorial_register_file_lanes_if #(.DEPTH(16), .LANES(4), .LANE_BITS(32)) bus ();
    vectorial_register_file_lanes #(.DEPTH(16), .LANES(4), .LANE_BITS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    int total = 0;
    int bad = 0;
    int clr_idx = -1;
    int busy_seen = 0;
    logic [VW-1:0] mdl [16];
    logic [VW-1:0] last1 = '0, last2 = '0;
    logic [2*VW-1:0] q [$];
    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [VW-1:0] view(input int a, input logic acc, input int aw, input logic [VW-1:0] d, input logic [3:0] m);
        logic [VW-1:0] v;
        v = mdl[a];
        if (acc && aw == a)
            for (int k = 0; k < 4; k++) if (m[k]) v[k*W +: W] = d[k*W +: W];
        return v;
    endfunction
    task automatic drive(input logic we, input int aw, input logic [VW-1:0] d, input logic [3:0] m,
                         input logic re, input int a1, input int a2, input logic cs);
        logic bz, acc, rv;
        logic [VW-1:0] e1, e2;
        bus.writeEn = we; bus.addressw = aw[3:0]; bus.writeData = d; bus.writeMask = m;
        bus.readEn = re; bus.address1 = a1[3:0]; bus.address2 = a2[3:0]; bus.clearStart = cs;
        bz  = clr_idx >= 0;
        acc = we && !bz && aw != 0;
        rv  = re && !bz;
        if (rv) begin
            e1 = view(a1, acc, aw, d, m);
            e2 = view(a2, acc, aw, d, m);
            q.push_back({e1, e2});
            last1 = e1;
            last2 = e2;
        end
        @(posedge clk);
        #1;
        if (acc) mdl[aw] = view(aw, acc, aw, d, m);
        if (bz) begin
            mdl[clr_idx] = '0;
            clr_idx = (clr_idx == 15) ? -1 : clr_idx + 1;
        end else if (cs) clr_idx = 0;
        chk("readValid", VW'(bus.readValid), VW'(rv));
        if (!rv) begin
            chk("hold1", bus.read1, last1);
            chk("hold2", bus.read2, last2);
        end
        chk("writeReject", VW'(bus.writeReject), VW'(we && bz));
        chk("busy", VW'(bus.busy), VW'(clr_idx >= 0));
        chk("clearDone", VW'(bus.clearDone), VW'(clr_idx == 15));
        if (bus.busy) busy_seen++;
        bus.writeEn = 1'b0; bus.readEn = 1'b0; bus.clearStart = 1'b0;
    endtask
    task automatic idle();
        drive(1'b0, 0, '0, 4'h0, 1'b0, 0, 0, 1'b0);
    endtask
    task automatic rd(input int a1, input int a2);
        drive(1'b0, 0, '0, 4'h0, 1'b1, a1, a2, 1'b0);
    endtask
    task automatic wr(input int aw, input logic [VW-1:0] d, input logic [3:0] m);
        drive(1'b1, aw, d, m, 1'b0, 0, 0, 1'b0);
    endtask
    task automatic fill();
        for (int i = 1; i < 16; i++) wr(i, {$urandom, $urandom, $urandom, $urandom | 32'h1}, 4'hF);
    endtask
    always @(negedge clk)
        if (bus.readValid) begin
            if (q.size() == 0) chk("rv_extra", VW'(1), VW'(0));
            else begin
                logic [2*VW-1:0] e;
                e = q.pop_front();
                chk("read1", bus.read1, e[2*VW-1:VW]);
                chk("read2", bus.read2, e[VW-1:0]);
            end
        end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        bus.writeEn = 1'b0; bus.readEn = 1'b0; bus.clearStart = 1'b0;
        bus.addressw = '0; bus.address1 = '0; bus.address2 = '0;
        bus.writeData = '0; bus.writeMask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read1", bus.read1, '0);
        chk("rst_read2", bus.read2, '0);
        chk("rst_readValid", VW'(bus.readValid), '0);
        chk("rst_busy", VW'(bus.busy), '0);
        chk("rst_clearDone", VW'(bus.clearDone), '0);
        chk("rst_writeReject", VW'(bus.writeReject), '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // masked write then read back
        wr(3, 128'h44444444_33333333_22222222_11111111, 4'b1111);
        wr(3, {4{32'hAAAAAAAA}}, 4'b0101);
        rd(3, 3);
        idle();
        // bypass on both ports into a zeroed register
        drive(1'b1, 5, {VW{1'b1}}, 4'b0011, 1'b1, 5, 5, 1'b0);
        rd(5, 3);
        // zero register ignores writes and bypass
        drive(1'b1, 0, {VW{1'b1}}, 4'b1111, 1'b1, 0, 3, 1'b0);
        rd(0, 0);
        // full clear with a rejected write and an ignored clearStart inside it
        fill();
        rd(7, 15);
        busy_seen = 0;
        drive(1'b0, 0, '0, 4'h0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) wr(4, {4{32'h12345678}}, 4'hF);
            else if (i == 5) drive(1'b0, 0, '0, 4'h0, 1'b0, 0, 0, 1'b1);
            else idle();
        end
        chk("busy_cycles", VW'(busy_seen), VW'(16));
        for (int i = 0; i < 16; i += 2) rd(i, i + 1);
        idle();
        // clearStart together with an accepted write
        wr(2, {4{32'h5A5A5A5A}}, 4'hF);
        rd(2, 2);
        drive(1'b1, 2, {4{32'hC3C3C3C3}}, 4'hF, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 16; i++) idle();
        rd(2, 3);
        // reset in the middle of a clear
        fill();
        rd(6, 9);
        drive(1'b0, 0, '0, 4'h0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 7; i++) idle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", VW'(bus.busy), '0);
        chk("mid_clearDone", VW'(bus.clearDone), '0);
        chk("mid_read1", bus.read1, '0);
        chk("mid_read2", bus.read2, '0);
        chk("mid_readValid", VW'(bus.readValid), '0);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        clr_idx = -1;
        last1 = '0;
        last2 = '0;
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        wr(9, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4'hF);
        rd(9, 6);
        idle();
        idle();
        chk("q_empty", VW'(q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
